// File: rtl/pop_fitness_eval.sv
// pop_fitness_eval: scores each genome as sum |gene - target| and packs scores for the sorter.
// Optional macro DIST_SAT_EN clamps sums to 2^DIST_W-2 instead of truncating.
module pop_fitness_eval #(
    parameter int POP    = 50,
    parameter int GENES  = 20,
    parameter int GENE_W = 8,
    parameter int DIST_W = 12,
    parameter int IDX_W  = $clog2(POP)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [GENES*GENE_W-1:0]   target_i,
    output logic                      mem_rd_o,
    output logic [IDX_W-1:0]          mem_addr_o,
    input  logic [GENES*GENE_W-1:0]   mem_data_i,
    output logic [POP*DIST_W-1:0]     distances_o,
    output logic                      sort_start_o,
    output logic                      busy_o,
    output logic                      done_o
);
    localparam int ACC_W = $clog2(GENES * (2**GENE_W - 1) + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(POP - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        rd_idx_q, rd_idx_d, wr_idx_q;
    logic                    wr_vld_q, sort_start_q;
    logic [POP*DIST_W-1:0]   dist_q, dist_d;
    logic [ACC_W-1:0]        acc;
    logic [DIST_W-1:0]       score;

    function automatic logic [GENE_W-1:0] absdiff(input logic [GENE_W-1:0] a, input logic [GENE_W-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rd_idx_q     <= '0;
            wr_vld_q     <= 1'b0;
            wr_idx_q     <= '0;
            sort_start_q <= 1'b0;
            dist_q       <= '0;
        end else begin
            state_q      <= state_d;
            rd_idx_q     <= rd_idx_d;
            wr_vld_q     <= mem_rd_o;
            wr_idx_q     <= rd_idx_q;
            sort_start_q <= (state_q == DRAIN);
            dist_q       <= dist_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        case (state_q)
            IDLE, DONE: if (start_i) begin
                state_d  = FETCH;
                rd_idx_d = '0;
            end
            FETCH: begin
                rd_idx_d = (rd_idx_q == LAST) ? rd_idx_q : rd_idx_q + 1'b1;
                state_d  = (rd_idx_q == LAST) ? DRAIN : FETCH;
            end
            default: state_d = DONE;
        endcase
    end

    always_comb begin
        mem_rd_o     = (state_q == FETCH);
        mem_addr_o   = rd_idx_q;
        busy_o       = (state_q == FETCH) || (state_q == DRAIN);
        done_o       = (state_q == DONE);
        sort_start_o = sort_start_q;
        distances_o  = dist_q;
    end

    always_comb begin
        acc = '0;
        for (int g = 0; g < GENES; g++)
            acc = acc + ACC_W'(absdiff(mem_data_i[g*GENE_W +: GENE_W], target_i[g*GENE_W +: GENE_W]));
    end

`ifdef DIST_SAT_EN
    // all-ones stays reserved as the sorter's "already taken" marker
    assign score = (acc >= ACC_W'(2**DIST_W - 1)) ? DIST_W'(2**DIST_W - 2) : acc[DIST_W-1:0];
`else
    logic unused_acc;
    assign unused_acc = ^acc[ACC_W-1:DIST_W];
    assign score = acc[DIST_W-1:0];
`endif

    always_comb begin
        dist_d = dist_q;
        if (wr_vld_q) dist_d[wr_idx_q*DIST_W +: DIST_W] = score;
    end
endmodule

// File: tb/tb_pop_fitness_eval.sv
// tb_pop_fitness_eval: directed scenario tests for pop_fitness_eval with a 1-cycle genome RAM model.
module tb_pop_fitness_eval;
    localparam int POP = 50, GENES = 20, GENE_W = 8, DIST_W = 12;
`ifdef DIST_SAT_EN
    localparam int SAT_EXP = 4094;
`else
    localparam int SAT_EXP = 1004;
`endif

    logic                    clk = 0, rst = 0, start_i = 0;
    logic [GENES*GENE_W-1:0] target_i = '0, mem_data_i = '0;
    logic                    mem_rd_o, sort_start_o, busy_o, done_o;
    logic [5:0]              mem_addr_o;
    logic [POP*DIST_W-1:0]   distances_o, exp_d, held;
    logic [GENES*GENE_W-1:0] mem [POP];
    int tests = 0, fails = 0;
    int ss_at, ss_cnt, addr_err, drain_rd;

    pop_fitness_eval dut (
        .clk(clk), .rst(rst), .start_i(start_i), .target_i(target_i),
        .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
        .distances_o(distances_o), .sort_start_o(sort_start_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mem_data_i <= mem_rd_o ? mem[mem_addr_o] : '0;

    task automatic fill_uniform(input int base, input int step);
        for (int i = 0; i < POP; i++)
            for (int g = 0; g < GENES; g++) mem[i][g*GENE_W +: GENE_W] = 8'((base + step * i) & 8'hFF);
    endtask

    task automatic set_target(input logic [7:0] v);
        for (int g = 0; g < GENES; g++) target_i[g*GENE_W +: GENE_W] = v;
    endtask

    // k = number of edges since the edge that sampled start
    task automatic do_pass(input bit glitch);
        ss_at = -1; ss_cnt = 0; addr_err = 0; drain_rd = 0;
        @(negedge clk) start_i = 1;
        @(negedge clk) start_i = 0;
        for (int k = 0; k < 60; k++) begin
            start_i = glitch && (k == 10 || k == 30);
            if (k < POP && !(mem_rd_o === 1'b1 && mem_addr_o === 6'(k))) addr_err++;
            if (k == POP && mem_rd_o !== 1'b0) drain_rd++;
            if (sort_start_o === 1'b1) begin
                if (ss_at < 0) ss_at = k;
                ss_cnt++;
            end
            @(negedge clk);
        end
        start_i = 0;
    endtask

    task automatic chk_slots(input string name);
        tests++;
        if (distances_o !== exp_d) begin
            fails++;
            $display("FAIL %s: distances got %h want %h", name, distances_o, exp_d);
        end
    endtask

    task automatic chk_pass(input string name);
        tests++;
        if (ss_at !== 51 || ss_cnt !== 1 || addr_err !== 0) begin
            fails++;
            $display("FAIL %s: ss_at=%0d ss_cnt=%0d addr_err=%0d want 51 1 0", name, ss_at, ss_cnt, addr_err);
        end
    endtask

    task automatic test_reset;
        int rd_seen = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({mem_rd_o, mem_addr_o, sort_start_o, busy_o, done_o} !== 10'b0 || distances_o !== '0) begin
            fails++;
            $display("FAIL reset_outputs: rd=%b addr=%0d ss=%b busy=%b done=%b dist_nz=%b want all 0",
                     mem_rd_o, mem_addr_o, sort_start_o, busy_o, done_o, |distances_o);
        end
        rst = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_rd_o !== 1'b0 || busy_o !== 1'b0) rd_seen++;
        end
        tests++;
        if (rd_seen != 0) begin
            fails++;
            $display("FAIL reset_idle: %0d active cycles after release, want 0", rd_seen);
        end
    endtask

    task automatic test_identical;
        fill_uniform(8'h5A, 0);
        set_target(8'h5A);
        do_pass(0);
        chk_pass("identical_pass");
        exp_d = '0;
        chk_slots("identical_slots");
        tests++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL identical_done: done=%b busy=%b want 1 0", done_o, busy_o);
        end
    endtask

    task automatic test_known_scores;
        fill_uniform(0, 0);
        for (int i = 0; i < POP; i++) mem[i][7:0] = 8'(i);
        set_target(0);
        do_pass(0);
        chk_pass("known_pass");
        for (int i = 0; i < POP; i++) exp_d[i*DIST_W +: DIST_W] = 12'(i);
        chk_slots("known_slots");
        tests++;
        if (drain_rd != 0) begin
            fails++;
            $display("FAIL drain_rd: mem_rd high in DRAIN, want low");
        end
    endtask

    task automatic test_saturation;
        fill_uniform(8'hFF, 0);
        set_target(0);
        do_pass(0);
        for (int i = 0; i < POP; i++) exp_d[i*DIST_W +: DIST_W] = 12'(SAT_EXP);
        chk_slots("saturation_slots");
    endtask

    task automatic test_abort;
        int n = 0;
        fill_uniform(0, 1);
        set_target(0);
        @(negedge clk) start_i = 1;
        @(negedge clk) start_i = 0;
        while (mem_addr_o !== 6'd20 && n < 60) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 60) begin
            fails++;
            $display("FAIL abort_reach: addr 20 never seen, last addr %0d", mem_addr_o);
        end
        rst = 1;
        @(negedge clk) rst = 0;
        tests++;
        if (busy_o !== 1'b0 || mem_rd_o !== 1'b0 || distances_o !== '0) begin
            fails++;
            $display("FAIL abort_state: busy=%b rd=%b dist_nz=%b want 0 0 0", busy_o, mem_rd_o, |distances_o);
        end
        repeat (2) @(negedge clk);
        do_pass(0);
        chk_pass("abort_pass");
        for (int i = 0; i < POP; i++) exp_d[i*DIST_W +: DIST_W] = 12'(20 * i);
        chk_slots("abort_slots");
    endtask

    task automatic test_back_to_back;
        fill_uniform(0, 1);
        set_target(10);
        do_pass(1);
        chk_pass("busy_ignore_pass");
        for (int i = 0; i < POP; i++) exp_d[i*DIST_W +: DIST_W] = 12'(20 * (i > 10 ? i - 10 : 10 - i));
        chk_slots("busy_ignore_slots");
        held = distances_o;
        repeat (5) @(negedge clk);
        tests++;
        if (distances_o !== held || sort_start_o !== 1'b0 || done_o !== 1'b1) begin
            fails++;
            $display("FAIL done_hold: ss=%b done=%b changed=%b want 0 1 0", sort_start_o, done_o, distances_o !== held);
        end
        set_target(40);
        do_pass(0);
        chk_pass("restart_pass");
        for (int i = 0; i < POP; i++) exp_d[i*DIST_W +: DIST_W] = 12'(20 * (i > 40 ? i - 40 : 40 - i));
        chk_slots("restart_slots");
    endtask

    initial begin
        test_reset;
        test_identical;
        test_known_scores;
        test_saturation;
        test_abort;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
